// File: rtl/ysyx_25020032_axi_arb_if.sv
// AXI4 bundles used by the arbiter: a read-only bundle for instruction fetch
// and a full read/write bundle for load/store and the shared slave port.
interface ysyx_25020032_axi_arb_rd_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (output arvalid, araddr, arid, arlen, arsize, arburst, rready,
                  input  arready, rvalid, rdata, rresp, rlast);
  modport slave  (input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
                  output arready, rvalid, rdata, rresp, rlast);
endinterface

interface ysyx_25020032_axi_arb_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (output arvalid, araddr, arid, arlen, arsize, arburst, rready,
                         awvalid, awaddr, awid, awlen, awsize, awburst,
                         wvalid, wdata, wstrb, wlast, bready,
                  input  arready, rvalid, rdata, rresp, rlast,
                         awready, wready, bvalid, bresp, bid);
  modport slave  (input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
                         awvalid, awaddr, awid, awlen, awsize, awburst,
                         wvalid, wdata, wstrb, wlast, bready,
                  output arready, rvalid, rdata, rresp, rlast,
                         awready, wready, bvalid, bresp, bid);
endinterface

// File: rtl/ysyx_25020032_axi_arb.sv
// Single-outstanding AXI arbiter: IFU (m0, read only) and LSU (m1) share one slave.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 always wins a tie.
module ysyx_25020032_axi_arb (
  input  logic                             clk,
  input  logic                             rst,
  ysyx_25020032_axi_arb_rd_if.slave        m0,
  ysyx_25020032_axi_arb_if.slave           m1,
  ysyx_25020032_axi_arb_if.master          s
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_M0 = 2'd1,
    RD_M1 = 2'd2,
    WR_M1 = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_m1_req;
  logic   w_m1_wins;
  logic   w_rd_done;
  logic   w_wr_done;

  assign w_m1_req  = m1.arvalid | m1.awvalid;
  assign w_rd_done = s.rvalid & s.rlast &
                     (((r_state == RD_M0) & m0.rready) | ((r_state == RD_M1) & m1.rready));
  assign w_wr_done = (r_state == WR_M1) & s.bvalid & m1.bready;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_m1;

  assign w_m1_wins = ~r_last_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_last_m1 <= 1'b0;
    else if (w_rd_done || w_wr_done) r_last_m1 <= (r_state != RD_M0);
  end
`else
  assign w_m1_wins = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awvalid  = 1'b0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        // A write beats a read from the same master; ties between masters use w_m1_wins.
        if (w_m1_req && (w_m1_wins || !m0.arvalid)) w_next = m1.awvalid ? WR_M1 : RD_M1;
        else if (m0.arvalid)                         w_next = RD_M0;
      end
      RD_M0: begin
        s.arvalid  = m0.arvalid;
        m0.arready = s.arready;
        m0.rvalid  = s.rvalid;
        s.rready   = m0.rready;
        if (w_rd_done) w_next = IDLE;
      end
      RD_M1: begin
        s.arvalid  = m1.arvalid;
        m1.arready = s.arready;
        m1.rvalid  = s.rvalid;
        s.rready   = m1.rready;
        if (w_rd_done) w_next = IDLE;
      end
      WR_M1: begin
        s.awvalid  = m1.awvalid;
        m1.awready = s.awready;
        s.wvalid   = m1.wvalid;
        m1.wready  = s.wready;
        m1.bvalid  = s.bvalid;
        s.bready   = m1.bready;
        if (w_wr_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Payloads are steered by state only; valids above decide whether they matter.
  assign s.araddr  = (r_state == RD_M1) ? m1.araddr  : m0.araddr;
  assign s.arid    = (r_state == RD_M1) ? m1.arid    : m0.arid;
  assign s.arlen   = (r_state == RD_M1) ? m1.arlen   : m0.arlen;
  assign s.arsize  = (r_state == RD_M1) ? m1.arsize  : m0.arsize;
  assign s.arburst = (r_state == RD_M1) ? m1.arburst : m0.arburst;

  assign s.awaddr  = m1.awaddr;
  assign s.awid    = m1.awid;
  assign s.awlen   = m1.awlen;
  assign s.awsize  = m1.awsize;
  assign s.awburst = m1.awburst;
  assign s.wdata   = m1.wdata;
  assign s.wstrb   = m1.wstrb;
  assign s.wlast   = m1.wlast;

  assign m0.rdata  = s.rdata;
  assign m0.rresp  = s.rresp;
  assign m0.rlast  = s.rlast;
  assign m1.rdata  = s.rdata;
  assign m1.rresp  = s.rresp;
  assign m1.rlast  = s.rlast;
  assign m1.bresp  = s.bresp;
  assign m1.bid    = s.bid;

endmodule

// File: tb/tb_ysyx_25020032_axi_arb.sv
// Directed self-checking bench for ysyx_25020032_axi_arb; expectations for the
// tie case follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_ysyx_25020032_axi_arb;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_M0 = 2'd1;
  localparam logic [1:0] S_RD_M1 = 2'd2;
  localparam logic [1:0] S_WR_M1 = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] st;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_25020032_axi_arb_rd_if m0 ();
  ysyx_25020032_axi_arb_if    m1 ();
  ysyx_25020032_axi_arb_if    s  ();

  ysyx_25020032_axi_arb dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0),
    .m1  (m1),
    .s   (s)
  );

  assign st = dut.r_state;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    m0.arvalid = 0; m0.araddr = '0; m0.arid = '0; m0.arlen = '0; m0.arsize = '0;
    m0.arburst = '0; m0.rready = 0;
    m1.arvalid = 0; m1.araddr = '0; m1.arid = '0; m1.arlen = '0; m1.arsize = '0;
    m1.arburst = '0; m1.rready = 0;
    m1.awvalid = 0; m1.awaddr = '0; m1.awid = '0; m1.awlen = '0; m1.awsize = '0;
    m1.awburst = '0; m1.wvalid = 0; m1.wdata = '0; m1.wstrb = '0; m1.wlast = 0;
    m1.bready = 0;
    s.arready = 0; s.rvalid = 0; s.rdata = '0; s.rresp = '0; s.rlast = 0;
    s.awready = 0; s.wready = 0; s.bvalid = 0; s.bresp = '0; s.bid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        first_m1;
    logic [31:0] first_addr;
    logic [31:0] second_addr;

    // Reset: outputs quiet even with a request pending.
    init_inputs();
    rst = 1'b1;
    m0.arvalid = 1; m0.araddr = 32'h1111_0000;
    #1;
    check("rst_state", st, S_IDLE);
    check("rst_s_arvalid", s.arvalid, 0);
    check("rst_m0_arready", m0.arready, 0);
    step(); step();
    check("rst_state_hold", st, S_IDLE);
    rst = 1'b0;
    m0.arvalid = 0;

    // m0 read of 0x2000_0000, data after 3 stall cycles.
    step();
    m0.arvalid = 1; m0.araddr = 32'h2000_0000; m0.arid = 4'h3; m0.arlen = 8'd0;
    m0.arsize = 3'd2; m0.arburst = 2'd1; m0.rready = 1;
    #1;
    check("t1_pre_state", st, S_IDLE);
    check("t1_pre_s_arvalid", s.arvalid, 0);
    step();
    check("t1_state", st, S_RD_M0);
    check("t1_s_arvalid", s.arvalid, 1);
    check("t1_s_araddr", s.araddr, 32'h2000_0000);
    check("t1_s_arid", s.arid, 4'h3);
    check("t1_s_arsize", s.arsize, 3'd2);
    check("t1_s_awvalid", s.awvalid, 0);
    s.arready = 1;
    #1;
    check("t1_m0_arready", m0.arready, 1);
    check("t1_m1_arready", m1.arready, 0);
    step();
    m0.arvalid = 0; s.arready = 0;
    repeat (3) step();
    s.rvalid = 1; s.rdata = 32'h0010_0073; s.rresp = 2'd0; s.rlast = 1;
    #1;
    check("t1_state_wait", st, S_RD_M0);
    check("t1_m0_rvalid", m0.rvalid, 1);
    check("t1_m0_rdata", m0.rdata, 32'h0010_0073);
    check("t1_m0_rresp", m0.rresp, 2'd0);
    check("t1_m1_rvalid", m1.rvalid, 0);
    check("t1_s_rready", s.rready, 1);
    step();
    s.rvalid = 0; s.rlast = 0;
    #1;
    check("t1_done_state", st, S_IDLE);
    check("t1_done_m0_rvalid", m0.rvalid, 0);

    // Unexpected responses in IDLE are not accepted.
    m1.bready = 1;
    s.rvalid = 1; s.bvalid = 1;
    #1;
    check("stray_s_rready", s.rready, 0);
    check("stray_s_bready", s.bready, 0);
    check("stray_m0_rvalid", m0.rvalid, 0);
    check("stray_m1_bvalid", m1.bvalid, 0);
    step();
    check("stray_state", st, S_IDLE);
    s.rvalid = 0; s.bvalid = 0;

    // m1 write to 0xA000_03F8; a concurrent m1 read must lose to the write.
    m1.awvalid = 1; m1.awaddr = 32'hA000_03F8; m1.awid = 4'h5; m1.awburst = 2'd1;
    m1.wvalid = 1; m1.wdata = 32'h41; m1.wstrb = 4'h1; m1.wlast = 1;
    m1.arvalid = 1; m1.araddr = 32'h0000_1234;
    step();
    m1.arvalid = 0;
    #1;
    check("t3_aw_prio_state", st, S_WR_M1);
    check("t3_s_awvalid", s.awvalid, 1);
    check("t3_s_awaddr", s.awaddr, 32'hA000_03F8);
    check("t3_s_awid", s.awid, 4'h5);
    check("t3_s_wvalid", s.wvalid, 1);
    check("t3_s_wdata", s.wdata, 32'h41);
    check("t3_s_wstrb", s.wstrb, 4'h1);
    check("t3_s_arvalid", s.arvalid, 0);
    check("t3_s_rready", s.rready, 0);
    m1.awvalid = 0; m1.wvalid = 0;
    #1;
    check("t3_drop_s_awvalid", s.awvalid, 0);
    step();
    check("t3_drop_state", st, S_WR_M1);
    m1.awvalid = 1; m1.wvalid = 1; s.awready = 1; s.wready = 1;
    #1;
    check("t3_m1_awready", m1.awready, 1);
    check("t3_m1_wready", m1.wready, 1);
    step();
    m1.awvalid = 0; m1.wvalid = 0; s.awready = 0; s.wready = 0;
    s.bvalid = 1; s.bresp = 2'd0; s.bid = 4'h5;
    #1;
    check("t3_m1_bvalid", m1.bvalid, 1);
    check("t3_m1_bresp", m1.bresp, 2'd0);
    check("t3_m1_bid", m1.bid, 4'h5);
    check("t3_s_bready", s.bready, 1);
    check("t3_m0_rvalid", m0.rvalid, 0);
    step();
    s.bvalid = 0;
    #1;
    check("t3_done_state", st, S_IDLE);

    // Simultaneous m0/m1 reads right after an m1 transaction.
`ifdef ARB_ROUND_ROBIN_EN
    first_m1 = 1'b0;
`else
    first_m1 = 1'b1;
`endif
    first_addr  = first_m1 ? 32'h0000_0200 : 32'h0000_0100;
    second_addr = first_m1 ? 32'h0000_0100 : 32'h0000_0200;
    m0.arvalid = 1; m0.araddr = 32'h0000_0100; m0.rready = 1;
    m1.arvalid = 1; m1.araddr = 32'h0000_0200; m1.rready = 1;
    step();
    check("t2_first_state", st, first_m1 ? S_RD_M1 : S_RD_M0);
    check("t2_first_araddr", s.araddr, first_addr);
    s.arready = 1;
    step();
    if (first_m1) m1.arvalid = 0; else m0.arvalid = 0;
    s.arready = 0; s.rvalid = 1; s.rdata = 32'h0000_AAAA; s.rlast = 1;
    #1;
    check("t2_first_m0_rvalid", m0.rvalid, first_m1 ? 1'b0 : 1'b1);
    check("t2_first_m1_rvalid", m1.rvalid, first_m1 ? 1'b1 : 1'b0);
    step();
    s.rvalid = 0; s.rlast = 0;
    #1;
    check("t2_gap_state", st, S_IDLE);
    check("t2_gap_s_arvalid", s.arvalid, 0);
    step();
    check("t2_second_state", st, first_m1 ? S_RD_M0 : S_RD_M1);
    check("t2_second_araddr", s.araddr, second_addr);
    s.arready = 1;
    step();
    if (first_m1) m0.arvalid = 0; else m1.arvalid = 0;
    s.arready = 0; s.rvalid = 1; s.rdata = 32'h0000_BBBB; s.rlast = 1;
    #1;
    check("t2_second_rdata", first_m1 ? m0.rdata : m1.rdata, 32'h0000_BBBB);
    check("t2_second_rvalid", first_m1 ? m0.rvalid : m1.rvalid, 1);
    step();
    s.rvalid = 0; s.rlast = 0;
    #1;
    check("t2_done_state", st, S_IDLE);

    // Two-beat m0 read with SLVERR on both beats; only the last beat completes.
    m0.arvalid = 1; m0.araddr = 32'h3000_0000;
    step();
    check("t4_state", st, S_RD_M0);
    s.arready = 1;
    step();
    m0.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'hDEAD_0001; s.rresp = 2'b10; s.rlast = 0;
    #1;
    check("t4_beat0_rresp", m0.rresp, 2'b10);
    check("t4_beat0_rdata", m0.rdata, 32'hDEAD_0001);
    step();
    check("t4_not_last_state", st, S_RD_M0);
    s.rdata = 32'hDEAD_0002; s.rlast = 1;
    #1;
    check("t4_beat1_rresp", m0.rresp, 2'b10);
    check("t4_beat1_rlast", m0.rlast, 1);
    step();
    s.rvalid = 0; s.rlast = 0; s.rresp = 2'd0;
    #1;
    check("t4_done_state", st, S_IDLE);

    // Reset mid-read on m1 while the slave stalls.
    m1.arvalid = 1; m1.araddr = 32'h0000_4000;
    step();
    check("t5_state", st, S_RD_M1);
    step();
    check("t5_stall_state", st, S_RD_M1);
    check("t5_stall_m1_arready", m1.arready, 0);
    rst = 1'b1; s.rvalid = 1; s.rlast = 1;
    #1;
    check("t5_rst_state", st, S_IDLE);
    check("t5_rst_s_arvalid", s.arvalid, 0);
    check("t5_rst_m1_rvalid", m1.rvalid, 0);
    step();
    rst = 1'b0; m1.arvalid = 0; s.rvalid = 0; s.rlast = 0;
    m0.arvalid = 1; m0.araddr = 32'h5000_0000;
    #1;
    check("t5_after_s_arvalid", s.arvalid, 0);
    check("t5_after_m1_rvalid", m1.rvalid, 0);
    step();
    check("t5_regrant_state", st, S_RD_M0);
    check("t5_regrant_araddr", s.araddr, 32'h5000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
